dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter RAM_BASE, default 32'h8000_0000; RAM byte base, aligned to 4*DEPTH_WORDS.
REQ-003 SHALL have parameter MMIO_BASE, default 32'h0010_0000; MMIO window base, 32-byte window.
REQ-004 SHALL have parameters SW_W and LED_W, default 16 each, both at most 32; switch and LED widths.
REQ-005 SHALL have parameters ID0 and ID1, defaults 32'h1719_2051 and 32'h1672_6992; read-only ID words.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-007 SHALL have request ports: req_valid  in  1  request present; req_ready  out  1  request accepted; req_we  in  1  store=1/load=0; req_addr  in  32  byte address; req_wdata  in  32  store data, LSB-aligned; req_size  in  2  00 byte, 01 half, 10 word, 11 illegal; req_unsigned  in  1  zero-extend load.
REQ-008 SHALL have response ports: rsp_valid  out  1  response strobe; rsp_rdata  out  32  load result; rsp_err  out  1  access fault.
REQ-009 SHALL have IO ports: switch_in  in  SW_W  asynchronous switches; led_out  out  LED_W  LED register.

Function
REQ-010 SHALL drive req_ready = !rst; a request is accepted on any clk edge with req_valid && req_ready, one per cycle, fully pipelined.
REQ-011 SHALL assert rsp_valid for exactly one cycle, on the cycle after acceptance, for every accepted load and store.
REQ-012 SHALL be little-endian: byte at addr[1:0]=0 occupies bits 7:0.
REQ-013 SHALL steer store bytes by size and addr[1:0]: byte->1 lane, half->lanes {1:0} or {3:2}, word->all 4; RAM write at the accepting edge.
REQ-014 SHALL read RAM synchronously at the accepting edge; the response shifts the selected bytes to bit 0 and sign-extends unless req_unsigned, in which case it zero-extends. Word loads ignore req_unsigned.
REQ-015 SHALL return newly written data for a load accepted the cycle after a store to the same address, with no stall.
REQ-016 SHALL decode RAM hits as RAM_BASE <= addr < RAM_BASE+4*DEPTH_WORDS and use index addr[log2(DEPTH_WORDS)+1:2].
REQ-017 SHALL decode MMIO offsets: 0x00 ID0 RO; 0x04 ID1 RO; 0x10 switches RO, 2-flop synchronised, zero-extended; 0x14 LED RW, reads zero-extended, writes take wdata[LED_W-1:0]; 0x18 CYCLE RO free-running 32-bit counter, wraps 0xFFFF_FFFF->0, and a store to it clears it to 0 on the next cycle.
REQ-018 SHALL set rsp_err=1 and rsp_rdata=0, with no state change, for: misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0), size 11, unmapped address, non-word MMIO access, or a store to ID0/ID1/switches.
REQ-019 SHALL drive rsp_rdata=0 on store responses and whenever rsp_valid=0.

Reset
REQ-020 SHALL reset rsp_valid, rsp_err, rsp_rdata, led_out, CYCLE and the synchroniser flops to 0 while rst is sampled high.
REQ-021 SHALL not initialise RAM contents.
REQ-022 SHALL suppress the response to a request accepted in the cycle before rst rises; no rsp_valid is produced after reset.

Structure
REQ-023 SHALL take size encodings, MMIO offsets and default base addresses from a shared package dmem_pkg.
REQ-024 SHALL build the RAM from four instances of sub-module dmem_byte_ram (one byte lane each: synchronous write enable, synchronous read, DEPTH_WORDS x 8).

Verification
REQ-025 SHALL check: store word 0xDEADBEEF to RAM_BASE+0x10, then load word from the same address -> rsp_valid one cycle after each request, rdata 0xDEADBEEF, err 0.
REQ-026 SHALL check: after REQ-025, load byte at +0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half at +0x12 signed -> 0xFFFFDEAD.
REQ-027 SHALL check: store half to RAM_BASE+0x11 -> err 1 and memory unchanged; load word from 0x0000_0000 -> err 1, rdata 0.
REQ-028 SHALL check: store 0x1234_5A5A to MMIO_BASE+0x14 -> led_out 0x5A5A; then load word -> 0x0000_5A5A; load word from +0x00 -> 0x1719_2051.
REQ-029 SHALL check: switch_in set to 0x00F0 -> an MMIO+0x10 load accepted 2 cycles later returns 0x000000F0; earlier loads return the old value.
REQ-030 SHALL check: back-to-back requests every cycle with rst pulsed for 1 cycle mid-stream -> no response for the request accepted just before reset; led_out and CYCLE are 0 after reset; CYCLE then increments by 1 per cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, MMIO map and helpers for the data memory with
// memory-mapped IO.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    localparam int unsigned DEPTH_WORDS_DEF = 1024;
    localparam logic [31:0] RAM_BASE_DEF    = 32'h8000_0000;
    localparam logic [31:0] MMIO_BASE_DEF   = 32'h0010_0000;
    localparam logic [31:0] ID0_DEF         = 32'h1719_2051;
    localparam logic [31:0] ID1_DEF         = 32'h1672_6992;

    localparam logic [4:0] OFF_ID0   = 5'h00;
    localparam logic [4:0] OFF_ID1   = 5'h04;
    localparam logic [4:0] OFF_SW    = 5'h10;
    localparam logic [4:0] OFF_LED   = 5'h14;
    localparam logic [4:0] OFF_CYCLE = 5'h18;

    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicating the low bytes lets each lane pick its own copy regardless of offset.
    function automatic logic [31:0] steer_store(input size_e sz, input logic [31:0] wdata);
        case (sz)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input size_e sz, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            SZ_BYTE: return uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// One byte lane of the data RAM: synchronous write, synchronous read.
module dmem_byte_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_mmio.sv
// Single-cycle pipelined data memory with a small MMIO window (IDs,
// switches, LEDs, cycle counter); one response per accepted request.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter logic [31:0] RAM_BASE    = RAM_BASE_DEF,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF,
    parameter int unsigned SW_W        = 16,
    parameter int unsigned LED_W       = 16,
    parameter logic [31:0] ID0         = ID0_DEF,
    parameter logic [31:0] ID1         = ID1_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    input  logic [SW_W-1:0]  switch_in,
    output logic [LED_W-1:0] led_out
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic            w_accept;
    size_e           w_size;
    logic            w_ram_hit;
    logic            w_mmio_hit;
    logic [4:0]      w_off;
    logic            w_misaligned;
    logic            w_mmio_err;
    logic [31:0]     w_mmio_rdata;
    logic            w_err;
    logic            w_ram_we;
    logic            w_led_we;
    logic            w_cyc_clr;
    logic [3:0]      w_lane_we;
    logic [31:0]     w_lane_wdata;
    logic [3:0][7:0] w_ram_dout;

    logic            r_valid;
    logic            r_err;
    logic            r_we;
    logic            r_is_ram;
    logic [1:0]      r_off;
    size_e           r_size;
    logic            r_unsigned;
    logic [31:0]     r_mmio_rdata;
    logic [SW_W-1:0] r_sw_meta;
    logic [SW_W-1:0] r_sw_sync;
    logic [LED_W-1:0] r_led;
    logic [31:0]     r_cycle;

    assign req_ready  = !rst;
    assign w_accept   = req_valid && !rst;
    assign w_size     = size_e'(req_size);
    assign w_ram_hit  = (req_addr[31:AW+2] == RAM_BASE[31:AW+2]);
    assign w_mmio_hit = (req_addr[31:5] == MMIO_BASE[31:5]);
    assign w_off      = req_addr[4:0];

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            SZ_HALF: w_misaligned = req_addr[0];
            SZ_WORD: w_misaligned = |req_addr[1:0];
            SZ_BAD:  w_misaligned = 1'b1;
            default: w_misaligned = 1'b0;
        endcase
    end

    // MMIO registers only accept word accesses; read-only ones also fault on stores.
    always_comb begin
        w_mmio_rdata = '0;
        w_mmio_err   = (w_size != SZ_WORD);
        case (w_off)
            OFF_ID0: begin
                w_mmio_rdata = ID0;
                if (req_we) w_mmio_err = 1'b1;
            end
            OFF_ID1: begin
                w_mmio_rdata = ID1;
                if (req_we) w_mmio_err = 1'b1;
            end
            OFF_SW: begin
                w_mmio_rdata = 32'(r_sw_sync);
                if (req_we) w_mmio_err = 1'b1;
            end
            OFF_LED:   w_mmio_rdata = 32'(r_led);
            OFF_CYCLE: w_mmio_rdata = r_cycle;
            default:   w_mmio_err   = 1'b1;
        endcase
    end

    assign w_err = w_misaligned
                 || (!w_ram_hit && !w_mmio_hit)
                 || (!w_ram_hit && w_mmio_hit && w_mmio_err);

    assign w_ram_we  = w_accept && req_we && w_ram_hit && !w_err;
    assign w_led_we  = w_accept && req_we && !w_ram_hit && w_mmio_hit && (w_off == OFF_LED) && !w_err;
    assign w_cyc_clr = w_accept && req_we && !w_ram_hit && w_mmio_hit && (w_off == OFF_CYCLE) && !w_err;

    assign w_lane_we    = w_ram_we ? lane_mask(w_size, req_addr[1:0]) : 4'b0000;
    assign w_lane_wdata = steer_store(w_size, req_wdata);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        dmem_byte_ram #(
            .DEPTH_WORDS (DEPTH_WORDS),
            .AW          (AW)
        ) u_lane (
            .i_clk   (clk),
            .i_we    (w_lane_we[g]),
            .i_addr  (req_addr[AW+1:2]),
            .i_wdata (w_lane_wdata[8*g +: 8]),
            .o_rdata (w_ram_dout[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_we         <= 1'b0;
            r_is_ram     <= 1'b0;
            r_off        <= 2'b00;
            r_size       <= SZ_BYTE;
            r_unsigned   <= 1'b0;
            r_mmio_rdata <= '0;
        end else begin
            r_valid      <= w_accept;
            r_err        <= w_accept && w_err;
            r_we         <= req_we;
            r_is_ram     <= w_ram_hit;
            r_off        <= req_addr[1:0];
            r_size       <= w_size;
            r_unsigned   <= req_unsigned;
            r_mmio_rdata <= w_mmio_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else if (w_led_we) begin
            r_led <= req_wdata[LED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_cyc_clr) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Gating with rst drops the response of a request accepted just before reset.
    always_comb begin
        rsp_valid = r_valid && !rst;
        rsp_err   = rsp_valid && r_err;
        rsp_rdata = '0;
        if (rsp_valid && !r_err && !r_we) begin
            rsp_rdata = r_is_ram ? load_extract(w_ram_dout, r_off, r_size, r_unsigned)
                                 : r_mmio_rdata;
        end
    end

    assign led_out = r_led;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: a pipelined vector table plus hand-written
// sequences for switch synchronisation, CYCLE clearing and mid-stream reset.
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] switch_in;
    logic [15:0] led_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        expErr;
        logic [31:0] expData;
        logic [15:0] expLed;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_mmio dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .switch_in    (switch_in),
        .led_out      (led_out)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.we, v.addr, v.wdata, v.size, v.uns);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkRsp(input string name, input logic expErr, input logic [31:0] expData);
        checkOutput({name, " valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({name, " err"},   32'(rsp_err),   32'(expErr));
        checkOutput({name, " rdata"}, rsp_rdata,      expData);
    endtask

    task automatic addVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input logic expErr,
                          input logic [31:0] expData, input logic [15:0] expLed);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.expErr = expErr; v.expData = expData; v.expLed = expLed;
        vecs.push_back(v);
    endtask

    initial begin
        //     we    addr           wdata          size   uns   err   data           led
        addVec(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 32'h0000_0000, 16'h0000);
        addVec(1'b0, 32'h8000_0010, 32'h0,         2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 16'h0000);
        addVec(1'b0, 32'h8000_0013, 32'h0,         2'b00, 1'b0, 1'b0, 32'hFFFF_FFDE, 16'h0000);
        addVec(1'b0, 32'h8000_0013, 32'h0,         2'b00, 1'b1, 1'b0, 32'h0000_00DE, 16'h0000);
        addVec(1'b0, 32'h8000_0012, 32'h0,         2'b01, 1'b0, 1'b0, 32'hFFFF_DEAD, 16'h0000);
        addVec(1'b1, 32'h8000_0011, 32'h0000_1111, 2'b01, 1'b0, 1'b1, 32'h0000_0000, 16'h0000);
        addVec(1'b0, 32'h8000_0010, 32'h0,         2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 16'h0000);
        addVec(1'b0, 32'h0000_0000, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h0000);
        addVec(1'b1, 32'h0010_0014, 32'h1234_5A5A, 2'b10, 1'b0, 1'b0, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h0010_0014, 32'h0,         2'b10, 1'b0, 1'b0, 32'h0000_5A5A, 16'h5A5A);
        addVec(1'b0, 32'h0010_0000, 32'h0,         2'b10, 1'b0, 1'b0, 32'h1719_2051, 16'h5A5A);
        addVec(1'b0, 32'h0010_0004, 32'h0,         2'b10, 1'b0, 1'b0, 32'h1672_6992, 16'h5A5A);
        addVec(1'b1, 32'h0010_0000, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h0010_0000, 32'h0,         2'b10, 1'b0, 1'b0, 32'h1719_2051, 16'h5A5A);
        addVec(1'b1, 32'h0010_0010, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h0010_0008, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h0010_0014, 32'h0,         2'b01, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b1, 32'h0010_0014, 32'h0,         2'b00, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b1, 32'h8000_0020, 32'h1122_3344, 2'b10, 1'b0, 1'b0, 32'h0000_0000, 16'h5A5A);
        addVec(1'b1, 32'h8000_0021, 32'h0000_00A5, 2'b00, 1'b0, 1'b0, 32'h0000_0000, 16'h5A5A);
        addVec(1'b1, 32'h8000_0022, 32'hFFFF_BEEF, 2'b01, 1'b0, 1'b0, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h8000_0020, 32'h0,         2'b10, 1'b0, 1'b0, 32'hBEEF_A544, 16'h5A5A);
        addVec(1'b0, 32'h8000_0020, 32'h0,         2'b01, 1'b1, 1'b0, 32'h0000_A544, 16'h5A5A);
        addVec(1'b0, 32'h8000_0020, 32'h0,         2'b01, 1'b0, 1'b0, 32'hFFFF_A544, 16'h5A5A);
        addVec(1'b0, 32'h8000_0020, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0000_0044, 16'h5A5A);
        addVec(1'b0, 32'h8000_0023, 32'h0,         2'b00, 1'b0, 1'b0, 32'hFFFF_FFBE, 16'h5A5A);
        addVec(1'b0, 32'h8000_0021, 32'h0,         2'b01, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h8000_0022, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h8000_0020, 32'h0,         2'b11, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b0, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h8000_0FFC, 32'h0,         2'b10, 1'b0, 1'b0, 32'hCAFE_F00D, 16'h5A5A);
        addVec(1'b0, 32'h8000_1000, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h7FFF_FFFC, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h8000_0010, 32'h0,         2'b10, 1'b1, 1'b0, 32'hDEAD_BEEF, 16'h5A5A);
        addVec(1'b0, 32'h8000_0011, 32'h0,         2'b00, 1'b0, 1'b0, 32'hFFFF_FFBE, 16'h5A5A);
        addVec(1'b0, 32'h8000_0010, 32'h0,         2'b01, 1'b0, 1'b0, 32'hFFFF_BEEF, 16'h5A5A);
        addVec(1'b0, 32'h0010_001C, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);
        addVec(1'b0, 32'h0010_0020, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0000, 16'h5A5A);

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        switch_in    = 16'h0000;
        repeat (3) tick();
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset led_out",   32'(led_out), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("run req_ready", 32'(req_ready), 32'd1);

        // Requests issue back-to-back, so each store is followed by its load with no gap.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkRsp($sformatf("vec%0d", i), vecs[i].expErr, vecs[i].expData);
            checkOutput($sformatf("vec%0d led", i), 32'(led_out), 32'(vecs[i].expLed));
        end
        req_valid = 1'b0;
        tick();
        checkOutput("idle rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle rsp_rdata", rsp_rdata, 32'd0);

        switch_in = 16'h00F0;
        drive(1'b0, 32'h0010_0010, 32'h0, 2'b10, 1'b0);
        tick();
        checkRsp("sw load1", 1'b0, 32'h0000_0000);
        tick();
        checkRsp("sw load2", 1'b0, 32'h0000_0000);
        tick();
        checkRsp("sw load3", 1'b0, 32'h0000_00F0);

        drive(1'b1, 32'h0010_0018, 32'hFFFF_FFFF, 2'b10, 1'b0);
        tick();
        checkRsp("cyc clear", 1'b0, 32'h0000_0000);
        drive(1'b0, 32'h0010_0018, 32'h0, 2'b10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkRsp($sformatf("cyc after clear %0d", k), 1'b0, 32'(k));
        end

        drive(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0);
        tick();
        checkRsp("pre-reset load", 1'b0, 32'hDEAD_BEEF);
        tick();
        rst = 1'b1;
        drive(1'b0, 32'h0010_0018, 32'h0, 2'b10, 1'b0);
        #1;
        checkOutput("suppressed rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("suppressed rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset req_ready low", 32'(req_ready), 32'd0);
        tick();
        checkOutput("post-reset led_out",   32'(led_out), 32'd0);
        checkOutput("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkRsp($sformatf("cyc after reset %0d", k), 1'b0, 32'(k));
        end
        req_valid = 1'b0;
        tick();
        checkOutput("final idle rsp_valid", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
